// File: rtl/mux_scan_sampler.sv
// Scans a 4-to-1 mux, channel 0..3, sampling f after SETTLE+1 cycles per channel into a 4-bit word.
// Optional output parity (XOR of q) is enabled by defining MUX_SCAN_PARITY_EN.
module mux_scan_sampler #(
  parameter int SETTLE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       f,
  output logic [1:0] S,
  output logic       busy,
  output logic       valid,
  input  logic       ready,
  output logic [0:3] q
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic       parity
`endif
);

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t     state_q;
  logic [1:0] sel_q;
  logic [3:0] cnt_q;
  logic [0:3] shadow_q;
  logic [0:3] shadow_d;
  logic [0:3] q_q;
  logic       last_tick;

  assign last_tick = (cnt_q == SETTLE_L);

  // Shadow word with the current channel's bit replaced, so the final load includes it.
  always_comb begin
    shadow_d        = shadow_q;
    shadow_d[sel_q] = f;
  end

`ifdef MUX_SCAN_PARITY_EN
  logic parity_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= 2'd0;
      cnt_q    <= 4'd0;
      shadow_q <= 4'b0000;
      q_q      <= 4'b0000;
`ifdef MUX_SCAN_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SCAN;
            sel_q   <= 2'd0;
            cnt_q   <= 4'd0;
          end
        end
        SCAN: begin
          if (last_tick) begin
            shadow_q <= shadow_d;
            cnt_q    <= 4'd0;
            if (sel_q == 2'd3) begin
              q_q     <= shadow_d;
              state_q <= HOLD;
              sel_q   <= 2'd0;
`ifdef MUX_SCAN_PARITY_EN
              parity_q <= ^shadow_d;
`endif
            end else begin
              sel_q <= sel_q + 2'd1;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        HOLD: begin
          if (ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          sel_q   <= 2'd0;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  assign S     = sel_q;
  assign busy  = (state_q == SCAN);
  assign valid = (state_q == HOLD);
  assign q     = q_q;
`ifdef MUX_SCAN_PARITY_EN
  assign parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Bench for mux_scan_sampler: two instances (SETTLE=0 and SETTLE=2) share stimulus and a timeline model.
module tb_mux_scan_sampler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       ready = 1'b0;
  logic [0:3] W = 4'b0000;

  logic [1:0] s0, s2;
  logic       b0, b2, v0, v2, f0, f2;
  logic [0:3] q0, q2;
`ifdef MUX_SCAN_PARITY_EN
  logic       p0, p2;
`endif

  // The external 4-to-1 mux: channel i carries W[i].
  assign f0 = W[s0];
  assign f2 = W[s2];

  mux_scan_sampler #(.SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .f(f0), .S(s0), .busy(b0),
    .valid(v0), .ready(ready), .q(q0)
`ifdef MUX_SCAN_PARITY_EN
    , .parity(p0)
`endif
  );

  mux_scan_sampler #(.SETTLE(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .f(f2), .S(s2), .busy(b2),
    .valid(v2), .ready(ready), .q(q2)
`ifdef MUX_SCAN_PARITY_EN
    , .parity(p2)
`endif
  );

  int errs = 0;
  int checks = 0;
  bit run_chk = 1'b0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%b required=%b at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a scan is a timeline of 4*N cycles (N = SETTLE+1); channel = k/N,
  // and channel c is sampled on the last cycle of its slot.
  int         NS[2] = '{1, 3};
  int         mode[2];   // 0 idle, 1 scanning, 2 holding
  int         k[2];
  logic [0:3] sh[2];
  logic [0:3] mq[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      mode[i] = 0; k[i] = 0; sh[i] = 4'b0000; mq[i] = 4'b0000;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mode[i] = 0; k[i] = 0; sh[i] = 4'b0000; mq[i] = 4'b0000;
      end else if (mode[i] == 0) begin
        if (start) begin mode[i] = 1; k[i] = 0; end
      end else if (mode[i] == 1) begin
        if (k[i] % NS[i] == NS[i] - 1) sh[i][k[i] / NS[i]] = W[k[i] / NS[i]];
        k[i] = k[i] + 1;
        if (k[i] == 4 * NS[i]) begin
          mq[i] = sh[i]; mode[i] = 2; k[i] = 0;
        end
      end else begin
        if (ready) mode[i] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      for (int i = 0; i < 2; i++) begin
        logic [1:0] as;
        logic       ab, av;
        logic [0:3] aq;
        as = (i == 0) ? s0 : s2;
        ab = (i == 0) ? b0 : b2;
        av = (i == 0) ? v0 : v2;
        aq = (i == 0) ? q0 : q2;
        chk($sformatf("S_%0d", i), 8'(as), (mode[i] == 1) ? 8'(k[i] / NS[i]) : 8'd0);
        chk($sformatf("busy_%0d", i), 8'(ab), 8'(mode[i] == 1));
        chk($sformatf("valid_%0d", i), 8'(av), 8'(mode[i] == 2));
        chk($sformatf("q_%0d", i), 8'(aq), 8'(mq[i]));
`ifdef MUX_SCAN_PARITY_EN
        chk($sformatf("parity_%0d", i), 8'((i == 0) ? p0 : p2), 8'(^mq[i]));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic handshake();
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  // Full scan on both instances; prev is the word that must still be held mid-scan.
  task automatic do_scan(input logic [0:3] w, input logic [0:3] prev);
    W = w;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("q0_mid", 8'(q0), 8'(prev));
    chk("q2_mid", 8'(q2), 8'(prev));
    repeat (9) tick();
    chk("q0_done", 8'(q0), 8'(w));
    chk("q2_done", 8'(q2), 8'(w));
    chk("v2_done", 8'(v2), 8'd1);
    chk("model_q2", 8'(mq[1]), 8'(w));
`ifdef MUX_SCAN_PARITY_EN
    chk("parity2_done", 8'(p2), 8'(^w));
`endif
    W = 4'($urandom);
    repeat (5) tick();
    chk("q2_stable", 8'(q2), 8'(w));
    chk("v2_stable", 8'(v2), 8'd1);
    handshake();
  endtask

  initial begin
    repeat (3) tick();
    run_chk = 1'b1;
    chk("rst_q0", 8'(q0), 8'd0);
    chk("rst_v2", 8'(v2), 8'd0);
    chk("rst_b2", 8'(b2), 8'd0);
    rst = 1'b0;

    // SETTLE=0: S steps 0..3, word appears four edges after start.
    W = 4'b1000;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk("S0_step", 8'(s0), 8'(j));
      chk("v0_early", 8'(v0), 8'd0);
      tick();
    end
    chk("v0_E4", 8'(v0), 8'd1);
    chk("q0_E4", 8'(q0), 8'b1000);
    chk("model_q0", 8'(mq[0]), 8'b1000);
    repeat (7) tick();
    chk("v2_E11", 8'(v2), 8'd0);
    tick();
    chk("v2_E12", 8'(v2), 8'd1);
    chk("q2_E12", 8'(q2), 8'b1000);
    handshake();
    chk("v0_after_hs", 8'(v0), 8'd0);

    do_scan(4'b1110, 4'b1000);
    do_scan(4'b0101, 4'b1110);
    do_scan(4'b1010, 4'b0101);

    // Reset mid-scan discards the partial word.
    W = 4'b1111;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("S2_before_rst", 8'(s2), 8'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_S2", 8'(s2), 8'd0);
    chk("rst_q2", 8'(q2), 8'd0);
    chk("rst_q0", 8'(q0), 8'd0);
    chk("rst_v0", 8'(v0), 8'd0);
    do_scan(4'b0011, 4'b0000);

    // start held high across HOLD and the handshake.
    W = 4'b1001;
    start = 1'b1;
    repeat (20) tick();
    handshake();
    chk("idle_after_hs", 8'(b0), 8'd0);
    tick();
    chk("restart_busy", 8'(b0), 8'd1);
    chk("restart_S", 8'(s0), 8'd0);
    start = 1'b0;
    repeat (15) tick();
    handshake();

    // Random traffic against the model.
    repeat (3000) begin
      start = ($urandom_range(0, 3) == 0);
      ready = ($urandom_range(0, 2) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      W     = 4'($urandom);
      tick();
    end
    rst = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mux_scan_sampler.md
MUX_SCAN_SAMPLER -- requirements
Module: mux_scan_sampler

Interface
REQ-001 Parameter: SETTLE, default 0, extra wait cycles per channel before f is sampled; legal range 0..15.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: start  input  1  request one 4-channel scan; sampled only in IDLE.
REQ-005 Port: f  input  1  selected data bit from the downstream 4-to-1 multiplexer.
REQ-006 Port: S  output  2  channel select driven to the 4-to-1 multiplexer; registered.
REQ-007 Port: busy  output  1  high while in SCAN.
REQ-008 Port: valid  output  1  high while a completed word is held; registered.
REQ-009 Port: ready  input  1  consumer accepts the word when valid && ready at a rising edge.
REQ-010 Port: q  output  [0:3]  assembled word; q[i] = f sampled while S == i.

Function
REQ-011 FSM states SHALL be IDLE, SCAN and HOLD, with S, busy and valid decoded from registered state only.
REQ-012 IDLE with start=1 at an edge SHALL move to SCAN with S=00 and settle counter=0; start=0 stays IDLE.
REQ-013 In SCAN each channel SHALL occupy exactly SETTLE+1 cycles; f SHALL be sampled into shadow bit [S] on the last of them.
REQ-014 After sampling channel S<3: S increments by 1 and the counter clears at that same edge.
REQ-015 After sampling channel 3: q loads the shadow word (including the bit just sampled), valid=1, state=HOLD, S returns to 00.
REQ-016 Latency: start sampled at edge E0, then q and valid update at edge E0 + 4*(SETTLE+1).
REQ-017 q SHALL change only at scan completion and SHALL hold its last word in IDLE and HOLD.
REQ-018 HOLD with ready=1 at an edge SHALL go to IDLE with valid=0; ready=0 holds valid=1 and q.
REQ-019 start SHALL be ignored in SCAN and HOLD, including start asserted in the same cycle as the handshake.
REQ-020 ready SHALL be ignored outside HOLD.
REQ-021 S SHALL not wrap past 11; no channel is sampled twice per scan.

Reset
REQ-022 rst=1 at an edge SHALL force IDLE with S=00, counter=0, shadow=0000, q=0000, valid=0 and busy=0, with priority over all other inputs.
REQ-023 rst during SCAN or HOLD SHALL abort the operation; the partial word is discarded and q is not updated.
REQ-024 After rst deasserts, a start in the first non-reset cycle SHALL be honoured.

Configuration
REQ-025 Macro MUX_SCAN_PARITY_EN, when defined, SHALL add output parity (1 bit) = XOR of q, updated with q and reset to 0.
REQ-026 Without MUX_SCAN_PARITY_EN the parity port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-027 SETTLE=0 with mux W=1000 and start pulse at E0 -> S steps 00,01,10,11; valid=1 and q=1000 after E4.
REQ-028 SETTLE=2 with W=1110 -> each S value held 3 cycles; q=1110 and valid after E12; with ready=0 for 5 cycles, valid and q remain stable.
REQ-029 W=0101 scan, handshake, then W=1010 scan -> q=0101 is held until the second completion, then q=1010; with the macro, parity=0 both times.
REQ-030 rst asserted with S=10 mid-scan -> next cycle IDLE, S=00, q=0000, valid=0; a new start with W=0011 yields q=0011.
REQ-031 start held high continuously with ready pulsed once in HOLD -> no restart until the cycle after IDLE is reached; start during SCAN causes no S glitch.
